// File: rtl/shift_row_bidir.sv
// Bidirectional shifting row with parallel load, clear, per-slot valid tracking,
// serial spill-out of the displaced element and a registered occupancy count.
module shift_row_bidir #(
  parameter  int DATA_WIDTH = 8,
  parameter  int ROW_WIDTH  = 5,
  localparam int CNT_WIDTH  = $clog2(ROW_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  shift_en,
  input  logic                  shift_dir,
  input  logic [DATA_WIDTH-1:0] shift_data,
  input  logic                  load_en,
  input  logic [DATA_WIDTH-1:0] load_data [ROW_WIDTH],
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] parallel_odata [ROW_WIDTH],
  output logic [ROW_WIDTH-1:0]  slot_valid,
  output logic [DATA_WIDTH-1:0] serial_odata,
  output logic                  serial_ovalid,
  output logic [CNT_WIDTH-1:0]  fill_count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] data_q [ROW_WIDTH];
  logic [DATA_WIDTH-1:0] data_d [ROW_WIDTH];
  logic [ROW_WIDTH-1:0]  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
  logic                  svalid_q, svalid_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    sdata_d  = sdata_q;
    svalid_d = 1'b0;
    if (clear) begin
      for (int unsigned k = 0; k < ROW_WIDTH; k++) data_d[k] = '0;
      valid_d = '0;
    end else if (load_en) begin
      data_d  = load_data;
      valid_d = '1;
    end else if (shift_en) begin
      if (!shift_dir) begin
        for (int unsigned k = 1; k < ROW_WIDTH; k++) data_d[k] = data_q[k-1];
        data_d[0] = shift_data;
        valid_d   = {valid_q[ROW_WIDTH-2:0], 1'b1};
        sdata_d   = data_q[ROW_WIDTH-1];
        svalid_d  = valid_q[ROW_WIDTH-1];
      end else begin
        for (int unsigned k = 0; k < ROW_WIDTH - 1; k++) data_d[k] = data_q[k+1];
        data_d[ROW_WIDTH-1] = shift_data;
        valid_d  = {1'b1, valid_q[ROW_WIDTH-1:1]};
        sdata_d  = data_q[0];
        svalid_d = valid_q[0];
      end
    end
    // Count is taken from the next-state valids so it lands in the same cycle.
    count_d = '0;
    for (int unsigned k = 0; k < ROW_WIDTH; k++) count_d = count_d + CNT_WIDTH'(valid_d[k]);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int unsigned k = 0; k < ROW_WIDTH; k++) data_q[k] <= '0;
      valid_q  <= '0;
      sdata_q  <= '0;
      svalid_q <= 1'b0;
      count_q  <= '0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      sdata_q  <= sdata_d;
      svalid_q <= svalid_d;
      count_q  <= count_d;
    end
  end

  assign parallel_odata = data_q;
  assign slot_valid     = valid_q;
  assign serial_odata   = sdata_q;
  assign serial_ovalid  = svalid_q;
  assign fill_count     = count_q;
  assign full           = (count_q == CNT_WIDTH'(ROW_WIDTH));
  assign empty          = (count_q == '0);

endmodule
